// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle ARMv4 control unit.
// State encoding, instruction field constants and the control-word bundle.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXECR, EXECI, EXECM, ALUWB, MEMADR,
      MEMRD, MEMWB, MEMWR, BRANCH, UNDEF, FAULT
   } state_t;

   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       irw;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] imm_src;
      logic [2:0] reg_src;
      logic       alu_op;
      logic       next_pc;
      logic       branch;
      logic       reg_w;
      logic       mem_w;
      logic       mul_start;
      logic       undef;
      logic       fault;
   } ctrl_t;

   // counter width able to hold 0..n-1, never zero bits
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction-field, memory handshake and datapath control bundle.
// master = control FSM side, slave = datapath / memory side.
interface multicycle_control_fsm_if;

   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MulOp;
   logic       mem_ready;

   logic       mem_req;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [2:0] RegSrc;
   logic       ALUOp;
   logic       NextPC;
   logic       Branch;
   logic       RegW;
   logic       MemW;
   logic       mul_start;
   logic       undef;
   logic       fault;

   modport master (
      input  Op, Funct, MulOp, mem_ready,
      output mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
      output ResultSrc, ImmSrc, RegSrc, ALUOp, NextPC,
      output Branch, RegW, MemW, mul_start, undef, fault
   );

   modport slave (
      output Op, Funct, MulOp, mem_ready,
      input  mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
      input  ResultSrc, ImmSrc, RegSrc, ALUOp, NextPC,
      input  Branch, RegW, MemW, mul_start, undef, fault
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Small up-counter with synchronous clear and terminal-value flag.
// Used for memory wait timeout and multiply latency.
module mem_wait_timer
   import ctrl_pkg::*;
#(
   parameter int N    = 16,
   parameter int LAST = 14
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expire
);

   localparam int W = cw(N);

   logic [W-1:0] q;

   // count up while enabled, restart on clear or reset
   always_ff @(posedge clk) begin
      if (!reset || clear) q <= '0;
      else if (count)      q <= q + 1'b1;
   end

   assign expire = (q == W'(LAST));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARMv4 control FSM with memory handshake and timeout fault.
// Define MUL_EN to add the EXECM multiply path (MUL_LAT cycles).
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int MUL_LAT     = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_control_fsm_if.master bus
);

   state_t     state;
   ctrl_t      c;
   logic       run_q;
   logic       rdy;
   logic       tm_clr;
   logic       tm_cnt;
   logic       tm_exp;
   logic       tm_hit;
   logic       mul_hit;
   logic       lat_done;
   logic [3:0] cmd;

   assign cmd = bus.Funct[4:1];

`ifdef MUL_EN
   logic mul_first;
   logic lat_exp;

   assign mul_hit  = bus.MulOp;
   assign lat_done = lat_exp;

   mem_wait_timer #(.N(MUL_LAT), .LAST(MUL_LAT-1)) u_lat (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != EXECM),
      .count  (state == EXECM),
      .expire (lat_exp)
   );
`else
   logic unused_mulop;

   assign unused_mulop = bus.MulOp;
   assign mul_hit      = 1'b0;
   assign lat_done     = 1'b1;
`endif

   // ready only counts while a request is actually out
   assign rdy    = bus.mem_ready & c.mem_req;
   assign tm_cnt = c.mem_req & ~bus.mem_ready;
   assign tm_clr = ~c.mem_req | bus.mem_ready;
   assign tm_hit = tm_cnt & tm_exp;

   mem_wait_timer #(.N(MEM_TIMEOUT), .LAST(MEM_TIMEOUT-2)) u_tmr (
      .clk    (clk),
      .reset  (reset),
      .clear  (tm_clr),
      .count  (tm_cnt),
      .expire (tm_exp)
   );

   // state sequencing per instruction class
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= FETCH;
         run_q <= 1'b0;
`ifdef MUL_EN
         mul_first <= 1'b0;
`endif
      end else begin
         run_q <= 1'b1;
`ifdef MUL_EN
         mul_first <= (state == DECODE);
`endif
         unique case (state)
            FETCH:
               if (rdy)         state <= DECODE;
               else if (tm_hit) state <= FAULT;
            DECODE:
               unique case (bus.Op)
                  OP_DP:
                     state <= bus.Funct[5] ? EXECI :
                              (mul_hit ? EXECM : EXECR);
                  OP_MEM: state <= MEMADR;
                  OP_BR:  state <= BRANCH;
                  OP_UND: state <= UNDEF;
               endcase
            EXECR, EXECI:
               state <= (cmd == CMD_CMP) ? FETCH : ALUWB;
            EXECM:
               if (lat_done) state <= ALUWB;
            MEMADR:
               state <= bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:
               if (rdy)         state <= MEMWB;
               else if (tm_hit) state <= FAULT;
            MEMWR:
               if (rdy)         state <= FETCH;
               else if (tm_hit) state <= FAULT;
            ALUWB, MEMWB, BRANCH, UNDEF:
               state <= FETCH;
            FAULT:
               state <= FAULT;
            default:
               state <= FETCH;
         endcase
      end
   end

   // state-decoded control word; reset forces everything low at once
   always_comb begin
      c = '0;
      unique case (state)
         FETCH: begin
            c.mem_req    = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.irw        = bus.mem_ready;
            c.next_pc    = bus.mem_ready;
         end
         DECODE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.imm_src   = (bus.Op == OP_UND) ? 2'b00 : bus.Op;
         end
         EXECR: begin
            c.alu_op     = 1'b1;
            c.reg_src[2] = (cmd == CMD_MOV);
         end
         EXECI: begin
            c.alu_op     = 1'b1;
            c.alu_src_b  = 2'b01;
            c.reg_src[2] = (cmd == CMD_MOV);
         end
         EXECM: begin
`ifdef MUL_EN
            c.mul_start = mul_first;
`endif
         end
         ALUWB: c.reg_w = 1'b1;
         MEMADR: begin
            c.alu_src_b  = 2'b01;
            c.imm_src    = 2'b01;
            c.reg_src[1] = ~bus.Funct[0];
         end
         MEMRD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         MEMWB: begin
            c.reg_w      = 1'b1;
            c.result_src = 2'b01;
         end
         MEMWR: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
            c.mem_w   = bus.mem_ready;
         end
         BRANCH: begin
            c.branch     = 1'b1;
            c.next_pc    = 1'b1;
            c.imm_src    = 2'b10;
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.reg_src[0] = 1'b1;
         end
         UNDEF: c.undef = 1'b1;
         FAULT: c.fault = 1'b1;
         default: ;
      endcase
      if (!(reset && run_q)) c = '0;
   end

   assign bus.mem_req   = c.mem_req;
   assign bus.IRWrite   = c.irw;
   assign bus.AdrSrc    = c.adr_src;
   assign bus.ALUSrcA   = c.alu_src_a;
   assign bus.ALUSrcB   = c.alu_src_b;
   assign bus.ResultSrc = c.result_src;
   assign bus.ImmSrc    = c.imm_src;
   assign bus.RegSrc    = c.reg_src;
   assign bus.ALUOp     = c.alu_op;
   assign bus.NextPC    = c.next_pc;
   assign bus.Branch    = c.branch;
   assign bus.RegW      = c.reg_w;
   assign bus.MemW      = c.mem_w;
   assign bus.mul_start = c.mul_start;
   assign bus.undef     = c.undef;
   assign bus.fault     = c.fault;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected
// control words are queued by the driver and popped by a monitor.
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   logic reset = 1'b0;

   multicycle_control_fsm_if bus();

   multicycle_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] mk(
      input logic mr, irw, adr, sa,
      input logic [1:0] sb, rs, im,
      input logic [2:0] rg,
      input logic ao, np, br, rw, mw, ms, ud, ft);
      return {mr, irw, adr, sa, sb, rs, im, rg,
              ao, np, br, rw, mw, ms, ud, ft};
   endfunction

   localparam logic [20:0] ZERO = '0;
   localparam logic [20:0] F_W  = mk(1,0,0,1,2'b10,2'b10,2'b00,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] F_R  = mk(1,1,0,1,2'b10,2'b10,2'b00,3'b000,0,1,0,0,0,0,0,0);
   localparam logic [20:0] D00  = mk(0,0,0,1,2'b10,2'b00,2'b00,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] D01  = mk(0,0,0,1,2'b10,2'b00,2'b01,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] D10  = mk(0,0,0,1,2'b10,2'b00,2'b10,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] XR0  = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0,0,0,0,0,0,0);
   localparam logic [20:0] XI0  = mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,0,0,0,0,0,0,0);
   localparam logic [20:0] XI4  = mk(0,0,0,0,2'b01,2'b00,2'b00,3'b100,1,0,0,0,0,0,0,0);
   localparam logic [20:0] WB   = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,1,0,0,0,0);
   localparam logic [20:0] MA_L = mk(0,0,0,0,2'b01,2'b00,2'b01,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] MA_S = mk(0,0,0,0,2'b01,2'b00,2'b01,3'b010,0,0,0,0,0,0,0,0);
   localparam logic [20:0] MACC = mk(1,0,1,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,0,0,0,0);
   localparam logic [20:0] MWB  = mk(0,0,0,0,2'b00,2'b01,2'b00,3'b000,0,0,0,1,0,0,0,0);
   localparam logic [20:0] MW_R = mk(1,0,1,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,1,0,0,0);
   localparam logic [20:0] BR   = mk(0,0,0,0,2'b01,2'b10,2'b10,3'b001,0,1,1,0,0,0,0,0);
   localparam logic [20:0] UND  = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,0,0,1,0);
   localparam logic [20:0] FLT  = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,0,0,0,1);
`ifdef MUL_EN
   localparam logic [20:0] MS   = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,0,1,0,0);
`endif

   typedef struct {
      logic [20:0] v;
      string       n;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   logic [20:0] act;

   assign act = {bus.mem_req, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc,
                 bus.ALUOp, bus.NextPC, bus.Branch, bus.RegW,
                 bus.MemW, bus.mul_start, bus.undef, bus.fault};

   // monitor: compare whatever the DUT presents against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL %s got=%b want=%b", e.n, act, e.v);
         end
      end
   end

   task automatic step(input logic r, input logic rdy,
                       input logic [20:0] e, input string n);
      exp_t x;
      @(posedge clk);
      #1;
      reset = r;
      bus.mem_ready = rdy;
      x.v = e;
      x.n = n;
      sbq.push_back(x);
   endtask

   task automatic setins(input logic [1:0] op, input logic [5:0] fn,
                         input logic mo);
      bus.Op = op;
      bus.Funct = fn;
      bus.MulOp = mo;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.mem_ready = 1'b0;
      setins(2'b00, 6'b001000, 1'b0);

      step(0, 0, ZERO, "rst0");
      step(0, 1, ZERO, "rst1");
      step(1, 0, ZERO, "rel");

      // ADD reg
      step(1, 1, F_R,  "add_f");
      step(1, 0, D00,  "add_d");
      step(1, 0, XR0,  "add_x");
      step(1, 0, WB,   "add_wb");

      // CMP imm: no writeback
      step(1, 1, F_R,  "cmp_f");
      setins(2'b00, 6'b110101, 1'b0);
      step(1, 0, D00,  "cmp_d");
      step(1, 0, XI0,  "cmp_x");

      // MOV imm: RegSrc[2]
      step(1, 1, F_R,  "mov_f");
      setins(2'b00, 6'b111010, 1'b0);
      step(1, 0, D00,  "mov_d");
      step(1, 0, XI4,  "mov_x");
      step(1, 0, WB,   "mov_wb");

      // LDR, ready 3 cycles late
      step(1, 1, F_R,  "ldr_f");
      setins(2'b01, 6'b011001, 1'b0);
      step(1, 0, D01,  "ldr_d");
      step(1, 0, MA_L, "ldr_a");
      step(1, 0, MACC, "ldr_w1");
      step(1, 0, MACC, "ldr_w2");
      step(1, 0, MACC, "ldr_w3");
      step(1, 1, MACC, "ldr_r");
      step(1, 0, MWB,  "ldr_wb");

      // STR: single MemW cycle
      step(1, 1, F_R,  "str_f");
      setins(2'b01, 6'b011000, 1'b0);
      step(1, 0, D01,  "str_d");
      step(1, 0, MA_S, "str_a");
      step(1, 0, MACC, "str_w");
      step(1, 1, MW_R, "str_r");
      step(1, 0, F_W,  "str_back");

      // B
      step(1, 1, F_R,  "b_f");
      setins(2'b10, 6'b000000, 1'b0);
      step(1, 0, D10,  "b_d");
      step(1, 0, BR,   "b_br");

      // undefined
      step(1, 1, F_R,  "und_f");
      setins(2'b11, 6'b000000, 1'b0);
      step(1, 0, D00,  "und_d");
      step(1, 0, UND,  "und");
      step(1, 0, F_W,  "und_back");

      // multiply pattern
      step(1, 1, F_R,  "mul_f");
      setins(2'b00, 6'b000000, 1'b1);
      step(1, 0, D00,  "mul_d");
`ifdef MUL_EN
      step(1, 0, MS,   "mul_m1");
      step(1, 0, ZERO, "mul_m2");
      step(1, 0, ZERO, "mul_m3");
`else
      step(1, 0, XR0,  "mul_x");
`endif
      step(1, 0, WB,   "mul_wb");

      // reset during a store handshake
      step(1, 1, F_R,  "s2_f");
      setins(2'b01, 6'b011000, 1'b0);
      step(1, 0, D01,  "s2_d");
      step(1, 0, MA_S, "s2_a");
      step(1, 0, MACC, "s2_w");
      step(0, 1, ZERO, "abort");
      step(1, 0, ZERO, "ab_rel");

      // fetch timeout: fault on the 16th request cycle
      step(1, 0, F_W,  "to_c1");
      for (int i = 2; i <= 15; i++) step(1, 0, F_W, "to_wait");
      step(1, 0, FLT,  "to_c16");
      step(1, 1, FLT,  "fault_sticky");
      step(1, 0, FLT,  "fault_sticky2");
      step(0, 0, ZERO, "frst");
      step(1, 0, ZERO, "frel");
      step(1, 0, F_W,  "f_after");

      @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
